// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, write-back bypass
// into the decode operands, flush/bubble insertion and a saturating stall counter.
module id_ex_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_Ra,
  input  logic [4:0]  id_Rb,
  input  logic [4:0]  id_Rw,
  input  logic [31:0] id_busA,
  input  logic [31:0] id_busB,
  input  logic [31:0] id_imm,
  input  logic        id_RegWr,
  input  logic        id_MemRead,
  input  logic        id_MemWr,
  input  logic [3:0]  id_ALUctr,
  input  logic        wb_RegWr,
  input  logic [4:0]  wb_Rw,
  input  logic [31:0] wb_busW,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_RegWr,
  output logic        ex_MemRead,
  output logic        ex_MemWr,
  output logic [3:0]  ex_ALUctr,
  output logic [4:0]  ex_Ra,
  output logic [4:0]  ex_Rb,
  output logic [4:0]  ex_Rw,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [31:0] ex_imm,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        mem_read;
    logic        mem_wr;
    logic [3:0]  alu_ctr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } ex_regs_t;

  ex_regs_t    ex_q, ex_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hz;
  logic        bubble;
  logic [31:0] op_a, op_b;

  // A load in EX whose destination is read by the decode-slot instruction.
  always_comb begin
    hz = ex_q.valid && ex_q.mem_read && ex_q.reg_wr && (ex_q.rw != 5'd0) &&
         id_valid && ((ex_q.rw == id_Ra) || (ex_q.rw == id_Rb));
    stall  = hz && !flush && !rst;
    bubble = flush || hz;
  end

  // Register file writes this cycle are not yet visible on id_busA/B; r0 is never bypassed.
  always_comb begin
    op_a = id_busA;
    op_b = id_busB;
    if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == id_Ra)) op_a = wb_busW;
    if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == id_Rb)) op_b = wb_busW;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;
    if (!bubble) begin
      ex_d.valid    = id_valid;
      ex_d.reg_wr   = id_valid && id_RegWr;
      ex_d.mem_read = id_valid && id_MemRead;
      ex_d.mem_wr   = id_valid && id_MemWr;
      ex_d.alu_ctr  = id_ALUctr;
      ex_d.ra       = id_Ra;
      ex_d.rb       = id_Rb;
      ex_d.rw       = id_Rw;
      ex_d.a        = op_a;
      ex_d.b        = op_b;
      ex_d.imm      = id_imm;
    end
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_RegWr   = ex_q.reg_wr;
  assign ex_MemRead = ex_q.mem_read;
  assign ex_MemWr   = ex_q.mem_wr;
  assign ex_ALUctr  = ex_q.alu_ctr;
  assign ex_Ra      = ex_q.ra;
  assign ex_Rb      = ex_q.rb;
  assign ex_Rw      = ex_q.rw;
  assign ex_A       = ex_q.a;
  assign ex_B       = ex_q.b;
  assign ex_imm     = ex_q.imm;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed testbench for id_ex_pipe: reset, normal load, invalid slot, bypass,
// load-use stall, flush priority, back-to-back loads, counter saturation and reset.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_Ra, id_Rb, id_Rw;
  logic [31:0] id_busA, id_busB, id_imm;
  logic        id_RegWr, id_MemRead, id_MemWr;
  logic [3:0]  id_ALUctr;
  logic        wb_RegWr;
  logic [4:0]  wb_Rw;
  logic [31:0] wb_busW;
  logic        flush;
  logic        stall;
  logic        ex_valid, ex_RegWr, ex_MemRead, ex_MemWr;
  logic [3:0]  ex_ALUctr;
  logic [4:0]  ex_Ra, ex_Rb, ex_Rw;
  logic [31:0] ex_A, ex_B, ex_imm;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  id_ex_pipe dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_Ra(id_Ra), .id_Rb(id_Rb), .id_Rw(id_Rw),
    .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
    .id_RegWr(id_RegWr), .id_MemRead(id_MemRead), .id_MemWr(id_MemWr),
    .id_ALUctr(id_ALUctr),
    .wb_RegWr(wb_RegWr), .wb_Rw(wb_Rw), .wb_busW(wb_busW),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_RegWr(ex_RegWr), .ex_MemRead(ex_MemRead), .ex_MemWr(ex_MemWr),
    .ex_ALUctr(ex_ALUctr), .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rw(ex_Rw),
    .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [118:0] ex_all = {ex_valid, ex_RegWr, ex_MemRead, ex_MemWr, ex_ALUctr,
                         ex_Ra, ex_Rb, ex_Rw, ex_A, ex_B, ex_imm};

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rw, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic rwr, input logic mrd,
                          input logic mwr, input logic [3:0] alu);
    id_valid = v;   id_Ra = ra;     id_Rb = rb;     id_Rw = rw;
    id_busA = a;    id_busB = b;    id_imm = imm;
    id_RegWr = rwr; id_MemRead = mrd; id_MemWr = mwr; id_ALUctr = alu;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rw, input logic [31:0] d);
    wb_RegWr = en; wb_Rw = rw; wb_busW = d;
  endtask

  // Load to r7 from base r2; becomes the EX-stage producer for a dependent op.
  task automatic issue_load_r7();
    drive_id(1'b1, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h4, 1'b1, 1'b1, 1'b0, 4'h0);
    tick();
  endtask

  // Consumer of r7 on port B, writing r8.
  task automatic drive_dep_r7();
    drive_id(1'b1, 5'd1, 5'd7, 5'd8, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive_wb(1'b1, 5'd3, 32'hFFFF_FFFF);
    drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 1'b1, 4'hF);
    tick();
    tick();
    n_checks++;
    if (ex_all !== '0) $display("FAIL reset_ex: got %h want 0", ex_all); else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'h0) $display("FAIL reset_cnt: got %h want 0", stall_cnt); else n_pass++;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
    rst = 1'b0;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
  endtask

  task automatic test_normal();
    drive_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h100, 1'b1, 1'b0, 1'b0, 4'h2);
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL normal_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if (ex_A !== 32'h11) $display("FAIL normal_A: got %h want 11", ex_A); else n_pass++;
    n_checks++;
    if (ex_B !== 32'h22) $display("FAIL normal_B: got %h want 22", ex_B); else n_pass++;
    n_checks++;
    if (ex_ALUctr !== 4'h2) $display("FAIL normal_alu: got %h want 2", ex_ALUctr); else n_pass++;
    n_checks++;
    if (ex_all !== {4'b1100, 4'h2, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h100})
      $display("FAIL normal_all: got %h", ex_all);
    else n_pass++;
  endtask

  task automatic test_invalid_slot();
    drive_id(1'b0, 5'd1, 5'd2, 5'd9, 32'h33, 32'h44, 32'h55, 1'b1, 1'b1, 1'b1, 4'h7);
    tick();
    n_checks++;
    if ({ex_valid, ex_RegWr, ex_MemRead, ex_MemWr} !== 4'b0000)
      $display("FAIL invalid_ctl: got %b want 0000", {ex_valid, ex_RegWr, ex_MemRead, ex_MemWr});
    else n_pass++;
    n_checks++;
    if ({ex_ALUctr, ex_Rw, ex_A} !== {4'h7, 5'd9, 32'h33})
      $display("FAIL invalid_data: got %h", {ex_ALUctr, ex_Rw, ex_A});
    else n_pass++;
  endtask

  task automatic test_bypass();
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    drive_id(1'b1, 5'd5, 5'd9, 5'd10, 32'h0, 32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    n_checks++;
    if ({ex_A, ex_B} !== {32'hDEAD_BEEF, 32'h99})
      $display("FAIL bypass_a: got %h %h want deadbeef 99", ex_A, ex_B);
    else n_pass++;
    drive_id(1'b1, 5'd1, 5'd5, 5'd10, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    n_checks++;
    if ({ex_A, ex_B} !== {32'h77, 32'hDEAD_BEEF})
      $display("FAIL bypass_b: got %h %h want 77 deadbeef", ex_A, ex_B);
    else n_pass++;
    drive_wb(1'b1, 5'd0, 32'hCAFE_F00D);
    drive_id(1'b1, 5'd0, 5'd0, 5'd10, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    n_checks++;
    if ({ex_A, ex_B} !== {32'h1234, 32'h5678})
      $display("FAIL bypass_r0: got %h %h want 1234 5678", ex_A, ex_B);
    else n_pass++;
    drive_wb(1'b0, 5'd5, 32'hCAFE_F00D);
    drive_id(1'b1, 5'd5, 5'd5, 5'd10, 32'h42, 32'h43, 32'h0, 1'b1, 1'b0, 1'b0, 4'h1);
    tick();
    n_checks++;
    if ({ex_A, ex_B} !== {32'h42, 32'h43})
      $display("FAIL bypass_nowr: got %h %h want 42 43", ex_A, ex_B);
    else n_pass++;
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_load_use();
    issue_load_r7();
    n_checks++;
    if ({ex_MemRead, ex_RegWr, ex_Rw} !== {2'b11, 5'd7})
      $display("FAIL lu_load: got %b", {ex_MemRead, ex_RegWr, ex_Rw});
    else n_pass++;
    drive_dep_r7();
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++;
    if (ex_all !== '0) $display("FAIL lu_bubble: got %h want 0", ex_all); else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd1) $display("FAIL lu_cnt: got %0d want 1", stall_cnt); else n_pass++;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL lu_release: got %b want 0", stall); else n_pass++;
    drive_wb(1'b1, 5'd7, 32'hABCD);
    tick();
    n_checks++;
    if ({ex_valid, ex_Rw, ex_A, ex_B} !== {1'b1, 5'd8, 32'h5, 32'hABCD})
      $display("FAIL lu_held: got %h want 1 08 5 abcd", {ex_valid, ex_Rw, ex_A, ex_B});
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd1) $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); else n_pass++;
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_flush_vs_hz();
    issue_load_r7();
    drive_dep_r7();
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if (ex_all !== '0) $display("FAIL flush_bubble: got %h want 0", ex_all); else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", stall_cnt); else n_pass++;
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue_load_r7();
    drive_id(1'b1, 5'd7, 5'd0, 5'd8, 32'h0, 32'h0, 32'h10, 1'b1, 1'b1, 1'b0, 4'h0);
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("FAIL b2b_stall1: got %b want 1", stall); else n_pass++;
    tick();
    drive_wb(1'b1, 5'd7, 32'h1000);
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL b2b_one1: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if ({ex_MemRead, ex_Rw, ex_A} !== {1'b1, 5'd8, 32'h1000})
      $display("FAIL b2b_load2: got %h want 1 08 1000", {ex_MemRead, ex_Rw, ex_A});
    else n_pass++;
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_id(1'b1, 5'd3, 5'd8, 5'd9, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'h2);
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("FAIL b2b_stall2: got %b want 1", stall); else n_pass++;
    tick();
    drive_wb(1'b1, 5'd8, 32'h77);
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL b2b_one2: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if ({ex_Rw, ex_B} !== {5'd9, 32'h77})
      $display("FAIL b2b_use: got %h want 09 77", {ex_Rw, ex_B});
    else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'd3) $display("FAIL b2b_cnt: got %0d want 3", stall_cnt); else n_pass++;
    drive_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_saturation_reset();
    // Skip ~65k load-use pairs by placing the counter just below its ceiling.
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    force dut.stall_cnt_q = 16'hFFFE;
    tick();
    release dut.stall_cnt_q;
    issue_load_r7();
    drive_dep_r7();
    tick();
    n_checks++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", stall_cnt); else n_pass++;
    issue_load_r7();
    drive_dep_r7();
    #1;
    n_checks++;
    if (stall !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", stall_cnt); else n_pass++;
    issue_load_r7();
    drive_dep_r7();
    rst = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if (ex_all !== '0) $display("FAIL rst_ex: got %h want 0", ex_all); else n_pass++;
    n_checks++;
    if (stall_cnt !== 16'h0) $display("FAIL rst_cnt: got %h want 0", stall_cnt); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) $display("FAIL rst_after_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++;
    if ({ex_valid, ex_RegWr, ex_Rw, ex_A, stall_cnt} !== {2'b11, 5'd8, 32'h5, 16'h0})
      $display("FAIL rst_normal: got %h", {ex_valid, ex_RegWr, ex_Rw, ex_A, stall_cnt});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_invalid_slot();
    test_bypass();
    test_load_use();
    test_flush_vs_hz();
    test_back_to_back();
    test_saturation_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
